ascii_uart_tx: RTL

ASCII_UART_TX -- requirements
Module: ascii_uart_tx

---
 rtl/ascii_uart_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/ascii_uart_tx.sv
// Serialises a latched two-digit ASCII value (plus optional line feed) as 8N1 frames.
// Bytes run back-to-back; busy covers the whole message and done pulses once at the end.
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit APPEND_LF    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ascii_in,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int         NBYTES    = APPEND_LF ? 3 : 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t      state;
  logic [15:0] bit_timer;
  logic [1:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [15:0] data_q;
  logic [7:0]  shift_q;

  function automatic logic [7:0] pick_byte(input logic [1:0] idx, input logic [15:0] d);
    case (idx)
      2'd0:    return d[15:8];
      2'd1:    return d[7:0];
      default: return 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_timer <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      shift_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            data_q    <= ascii_in;
            shift_q   <= ascii_in[15:8];
            byte_idx  <= '0;
            bit_timer <= BIT_LAST;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START_BIT;
          end
        end
        START_BIT: begin
          if (bit_timer == '0) begin
            bit_timer <= BIT_LAST;
            bit_idx   <= '0;
            tx        <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state     <= DATA_BITS;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        DATA_BITS: begin
          if (bit_timer == '0) begin
            bit_timer <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        STOP_BIT: begin
          if (bit_timer == '0) begin
            if (byte_idx == LAST_BYTE) begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              // Next byte's start bit follows the stop bit with no idle gap.
              byte_idx  <= byte_idx + 2'd1;
              shift_q   <= pick_byte(byte_idx + 2'd1, data_q);
              bit_timer <= BIT_LAST;
              tx        <= 1'b0;
              state     <= START_BIT;
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
